// File: rtl/cash_transaction_unit.sv
// Cash transaction controller: collects coins, vends against credit and pays change
// greedily in DENOM_HI and unit coins through a ready/valid change hopper.
module cash_transaction_unit #(
  parameter int unsigned W          = 8,
  parameter int unsigned MAX_CREDIT = 200,
  parameter int unsigned DENOM_HI   = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         coin_valid,
  input  logic [W-1:0] coin_value,
  input  logic         buy_valid,
  input  logic [W-1:0] product_cost,
  input  logic         cancel,
  input  logic         chg_ready,
  output logic [W-1:0] credit,
  output logic [W-1:0] balance,
  output logic         busy,
  output logic         coin_reject,
  output logic         vend,
  output logic         insufficient,
  output logic         chg_valid,
  output logic         chg_is_hi
);

  typedef enum logic [1:0] {StIdle, StCollect, StVend, StChange} state_e;

  localparam logic [W:0]   MaxCreditExt = (W+1)'(MAX_CREDIT);
  localparam logic [W-1:0] DenomHi      = W'(DENOM_HI);
  localparam logic [W-1:0] DenomLo      = W'(1);

  state_e         state_q, state_d;
  logic [W-1:0]   credit_q, credit_d;
  logic [W-1:0]   balance_q, balance_d;
  logic           busy_q, busy_d;
  logic           coin_reject_q, coin_reject_d;
  logic           vend_q, vend_d;
  logic           insufficient_q, insufficient_d;
  logic           chg_valid_q, chg_valid_d;
  logic           chg_is_hi_q, chg_is_hi_d;

  // Decision flags shared between the next-state and output processes
  logic           ev_coin_refused;
  logic           ev_buy_ok;
  logic           ev_buy_refused;
  logic [W:0]     coin_sum;
  logic [W-1:0]   chg_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      credit_q       <= '0;
      balance_q      <= '0;
      busy_q         <= 1'b0;
      coin_reject_q  <= 1'b0;
      vend_q         <= 1'b0;
      insufficient_q <= 1'b0;
      chg_valid_q    <= 1'b0;
      chg_is_hi_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      balance_q      <= balance_d;
      busy_q         <= busy_d;
      coin_reject_q  <= coin_reject_d;
      vend_q         <= vend_d;
      insufficient_q <= insufficient_d;
      chg_valid_q    <= chg_valid_d;
      chg_is_hi_q    <= chg_is_hi_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    credit_d        = credit_q;
    balance_d       = balance_q;
    ev_coin_refused = 1'b0;
    ev_buy_ok       = 1'b0;
    ev_buy_refused  = 1'b0;
    coin_sum        = {1'b0, credit_q} + {1'b0, coin_value};
    chg_step        = (balance_q >= DenomHi) ? DenomHi : DenomLo;
    unique case (state_q)
      StIdle, StCollect: begin
        if (cancel && (state_q == StCollect)) begin
          // Any coin arriving alongside a taken cancel or buy is handed back
          ev_coin_refused = coin_valid;
          balance_d       = credit_q;
          credit_d        = '0;
          state_d         = StChange;
        end else if (buy_valid) begin
          ev_coin_refused = coin_valid;
          if ((state_q == StCollect) && (credit_q >= product_cost)) begin
            ev_buy_ok = 1'b1;
            balance_d = credit_q - product_cost;
            credit_d  = '0;
            state_d   = StVend;
          end else begin
            ev_buy_refused = 1'b1;
          end
        end else if (coin_valid && (coin_value != '0)) begin
          if (coin_sum <= MaxCreditExt) begin
            credit_d = coin_sum[W-1:0];
            state_d  = StCollect;
          end else begin
            ev_coin_refused = 1'b1;
          end
        end
      end
      StVend: begin
        ev_coin_refused = coin_valid;
        state_d         = (balance_q != '0) ? StChange : StIdle;
      end
      StChange: begin
        ev_coin_refused = coin_valid;
        if (chg_ready && (balance_q != '0)) begin
          balance_d = balance_q - chg_step;
          if (balance_q == chg_step) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_d         = (state_d == StVend) || (state_d == StChange);
    coin_reject_d  = ev_coin_refused;
    vend_d         = ev_buy_ok;
    insufficient_d = ev_buy_refused;
    chg_valid_d    = (state_d == StChange);
    chg_is_hi_d    = (state_d == StChange) && (balance_d >= DenomHi);
  end

  assign credit       = credit_q;
  assign balance      = balance_q;
  assign busy         = busy_q;
  assign coin_reject  = coin_reject_q;
  assign vend         = vend_q;
  assign insufficient = insufficient_q;
  assign chg_valid    = chg_valid_q;
  assign chg_is_hi    = chg_is_hi_q;

endmodule

// File: tb/tb_cash_transaction_unit.sv
// Bench for cash_transaction_unit: directed scenarios then random traffic, every cycle
// compared against a credit/balance reference model.
module tb_cash_transaction_unit;

  localparam int W    = 8;
  localparam int MAXC = 200;
  localparam int D    = 10;

  logic         clk;
  logic         rst;
  logic         coin_valid;
  logic [W-1:0] coin_value;
  logic         buy_valid;
  logic [W-1:0] product_cost;
  logic         cancel;
  logic         chg_ready;
  logic [W-1:0] credit;
  logic [W-1:0] balance;
  logic         busy;
  logic         coin_reject;
  logic         vend;
  logic         insufficient;
  logic         chg_valid;
  logic         chg_is_hi;

  int checks = 0;
  int errors = 0;

  // Reference model: idle means zero credit and nothing owed
  int m_credit = 0;
  int m_bal    = 0;
  bit m_vend   = 0;
  int m_rej    = 0;
  int m_vendp  = 0;
  int m_ins    = 0;

  int n_hi = 0;
  int n_lo = 0;

  cash_transaction_unit #(
    .W          (W),
    .MAX_CREDIT (MAXC),
    .DENOM_HI   (D)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .coin_valid   (coin_valid),
    .coin_value   (coin_value),
    .buy_valid    (buy_valid),
    .product_cost (product_cost),
    .cancel       (cancel),
    .chg_ready    (chg_ready),
    .credit       (credit),
    .balance      (balance),
    .busy         (busy),
    .coin_reject  (coin_reject),
    .vend         (vend),
    .insufficient (insufficient),
    .chg_valid    (chg_valid),
    .chg_is_hi    (chg_is_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int v;
    int cost;
    v = int'(coin_value);
    cost = int'(product_cost);
    m_rej = 0;
    m_vendp = 0;
    m_ins = 0;
    if (rst) begin
      m_credit = 0;
      m_bal = 0;
      m_vend = 0;
    end else if (m_vend) begin
      m_vend = 0;
      m_rej = int'(coin_valid);
    end else if (m_bal > 0) begin
      m_rej = int'(coin_valid);
      if (chg_ready) m_bal = m_bal - ((m_bal >= D) ? D : 1);
    end else if (cancel && m_credit > 0) begin
      m_rej = int'(coin_valid);
      m_bal = m_credit;
      m_credit = 0;
    end else if (buy_valid) begin
      m_rej = int'(coin_valid);
      if (m_credit > 0 && m_credit >= cost) begin
        m_bal = m_credit - cost;
        m_credit = 0;
        m_vend = 1;
        m_vendp = 1;
      end else begin
        m_ins = 1;
      end
    end else if (coin_valid && v > 0) begin
      if (m_credit + v <= MAXC) m_credit = m_credit + v;
      else m_rej = 1;
    end
  endtask

  task automatic check_outputs();
    bit cv;
    cv = !m_vend && (m_bal > 0);
    chk("credit", credit, m_credit);
    chk("balance", balance, m_bal);
    chk("busy", busy, int'(m_vend || m_bal > 0));
    chk("coin_reject", coin_reject, m_rej);
    chk("vend", vend, m_vendp);
    chk("insufficient", insufficient, m_ins);
    chk("chg_valid", chg_valid, int'(cv));
    chk("chg_is_hi", chg_is_hi, int'(cv && m_bal >= D));
  endtask

  task automatic cycle();
    if (chg_valid === 1'b1 && chg_ready === 1'b1) begin
      if (chg_is_hi) n_hi++;
      else n_lo++;
    end
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic step(input bit cv, input int val, input bit bv, input int cost,
                      input bit cn, input bit rdy);
    coin_valid   = cv;
    coin_value   = W'(val);
    buy_valid    = bv;
    product_cost = W'(cost);
    cancel       = cn;
    chg_ready    = rdy;
    cycle();
    coin_valid = 1'b0;
    buy_valid  = 1'b0;
    cancel     = 1'b0;
  endtask

  task automatic coin(input int val);
    step(1, val, 0, 0, 0, 0);
  endtask

  task automatic drain(input string tag, input int exp_hi, input int exp_lo);
    int k;
    k = 0;
    while ((m_bal > 0 || m_vend) && k < 100) begin
      step(0, 0, 0, 0, 0, 1);
      k++;
    end
    chk({tag, "_settled"}, balance, 0);
    chk({tag, "_hi_coins"}, 32'(n_hi), exp_hi);
    chk({tag, "_lo_coins"}, 32'(n_lo), exp_lo);
    chg_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    coin_valid = 1'b0;
    coin_value = '0;
    buy_valid = 1'b0;
    product_cost = '0;
    cancel = 1'b0;
    chg_ready = 1'b0;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Buy in idle is refused; zero-value coin silently ignored
    step(0, 0, 1, 0, 0, 0);
    coin(0);

    // 50+20+5, buy 65: one large coin of change
    coin(50); coin(20); coin(5);
    chk("sale_credit", credit, 75);
    n_hi = 0; n_lo = 0;
    step(0, 0, 1, 65, 0, 1);
    chk("sale_vend", vend, 1);
    drain("sale", 1, 0);
    chk("sale_idle_credit", credit, 0);

    // Credit 30, buy 45 refused, then cancel refunds three large coins
    coin(20); coin(10);
    step(0, 0, 1, 45, 0, 0);
    chk("short_ins", insufficient, 1);
    chk("short_credit", credit, 30);
    n_hi = 0; n_lo = 0;
    step(0, 0, 0, 0, 1, 1);
    drain("refund30", 3, 0);

    // Ceiling: 195 + 10 rejected, 195 + 5 reaches 200 exactly
    coin(100); coin(95); coin(10);
    chk("cap_reject", coin_reject, 1);
    coin(5);
    chk("cap_credit", credit, 200);
    n_hi = 0; n_lo = 0;
    step(0, 0, 1, 200, 0, 1);
    drain("exact", 0, 0);

    // Credit 23, cost 0, hopper stalled: presented coin must hold
    coin(20); coin(3);
    n_hi = 0; n_lo = 0;
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
    drain("stall", 2, 3);

    // Cancel, buy and coin together: cancel wins, coin handed back
    coin(20); coin(20);
    n_hi = 0; n_lo = 0;
    step(1, 5, 1, 10, 1, 0);
    chk("tie_reject", coin_reject, 1);
    chk("tie_balance", balance, 40);
    drain("tie", 4, 0);

    // Reset in the middle of paying out 7
    coin(7);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    do_reset();
    chk("rst_balance", balance, 0);
    chk("rst_chg_valid", chg_valid, 0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 80) == 0);
      step(($urandom_range(0, 2) == 0), $urandom_range(0, 70),
           ($urandom_range(0, 6) == 0), $urandom_range(0, 150),
           ($urandom_range(0, 12) == 0), ($urandom_range(0, 1) == 1));
      rst = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
